// File: rtl/booth_pp_gen_12x24_pkg.sv
// Shared constants and the packed row-vector type for the 12x24 multiplier path.
// The same bus type is used by the partial-product generator, the reduction tree
// and the final adder.
package booth_pp_gen_12x24_pkg;

  localparam int OPW = 12;
  localparam int PPW = 24;
  localparam int NPP = 12;

  // Row vector: element i is partial-product row i, in tree row order.
  typedef logic [NPP-1:0][PPW-1:0] pp_bus_t;

  // Widen an operand to full product width, sign- or zero-extended.
  function automatic logic signed [PPW-1:0] ext_operand(input logic [OPW-1:0] a,
                                                        input logic           is_signed);
    logic signed [PPW-1:0] r;
    if (is_signed) r = {{(PPW-OPW){a[OPW-1]}}, a};
    else           r = {{(PPW-OPW){1'b0}}, a};
    return r;
  endfunction

endpackage

// File: rtl/booth_pp_gen_12x24_row.sv
// One partial-product row. The top row carries the multiplier sign bit; for signed
// operands it has weight -2^11, so it selects the negated multiplicand instead.
module pp_row_gen
  import booth_pp_gen_12x24_pkg::*;
#(
  parameter int ROW = 0
) (
  input  logic signed [PPW-1:0] a_ext,
  input  logic signed [PPW-1:0] a_neg,
  input  logic                  b_bit,
  input  logic                  is_signed,
  output logic signed [PPW-1:0] row
);

  logic signed [PPW-1:0] base;

  assign base = ((ROW == NPP-1) && is_signed) ? a_neg : a_ext;

  // Shift into place; bits pushed past the top of the row are dropped (mod 2^24).
  always_comb begin
    row = '0;
    if (b_bit) row = base << ROW;
  end

endmodule

// File: rtl/booth_pp_gen_12x24.sv
// Operand front end for the 12-row carry-save tree: two-stage registered pipeline
// with valid/ready on both sides and full backpressure.
module booth_pp_gen_12x24
  import booth_pp_gen_12x24_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  input  logic           in_signed,
  output logic           pp_valid,
  input  logic           pp_ready,
  output logic [PPW-1:0] pp0,
  output logic [PPW-1:0] pp1,
  output logic [PPW-1:0] pp2,
  output logic [PPW-1:0] pp3,
  output logic [PPW-1:0] pp4,
  output logic [PPW-1:0] pp5,
  output logic [PPW-1:0] pp6,
  output logic [PPW-1:0] pp7,
  output logic [PPW-1:0] pp8,
  output logic [PPW-1:0] pp9,
  output logic [PPW-1:0] pp10,
  output logic [PPW-1:0] pp11
);

  logic                  vld_p1, vld_p2;
  logic                  s2_acc;
  logic signed [PPW-1:0] a_ext_p0, a_neg_p0;
  logic signed [PPW-1:0] a_ext_p1, a_neg_p1;
  logic [OPW-1:0]        b_p1;
  logic                  sgn_p1;
  pp_bus_t               rows_c, rows_p2;

  // S2 can take a new op when empty or when its current op leaves this cycle.
  assign s2_acc   = !vld_p2 || pp_ready;
  assign in_ready = !vld_p1 || s2_acc;
  assign pp_valid = vld_p2;

  // ---- Stage P0 -> P1: operand extension and negation ----
  assign a_ext_p0 = ext_operand(in_a, in_signed);
  assign a_neg_p0 = -a_ext_p0;

  // Valid bits advance with the handshake; reset empties the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (s2_acc)   vld_p2 <= vld_p1;
    end
  end

  // S1 operand registers load only on an accepted input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ext_p1 <= '0;
      a_neg_p1 <= '0;
      b_p1     <= '0;
      sgn_p1   <= 1'b0;
    end else if (in_valid && in_ready) begin
      a_ext_p1 <= a_ext_p0;
      a_neg_p1 <= a_neg_p0;
      b_p1     <= in_b;
      sgn_p1   <= in_signed;
    end
  end

  // ---- Stage P1 -> P2: row generation ----
  for (genvar g = 0; g < NPP; g++) begin : g_row
    pp_row_gen #(.ROW(g)) u_row (
      .a_ext     (a_ext_p1),
      .a_neg     (a_neg_p1),
      .b_bit     (b_p1[g]),
      .is_signed (sgn_p1),
      .row       (rows_c[g])
    );
  end

  // Row registers load when S1 hands its op over; otherwise they hold (stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rows_p2 <= '0;
    else if (vld_p1 && s2_acc) rows_p2 <= rows_c;
  end

  // ---- Stage P2: outputs to the tree ----
  assign pp0  = rows_p2[0];
  assign pp1  = rows_p2[1];
  assign pp2  = rows_p2[2];
  assign pp3  = rows_p2[3];
  assign pp4  = rows_p2[4];
  assign pp5  = rows_p2[5];
  assign pp6  = rows_p2[6];
  assign pp7  = rows_p2[7];
  assign pp8  = rows_p2[8];
  assign pp9  = rows_p2[9];
  assign pp10 = rows_p2[10];
  assign pp11 = rows_p2[11];

endmodule

// File: tb/tb_booth_pp_gen_12x24.sv
// Bench for booth_pp_gen_12x24: directed steps with a scoreboard of expected rows
// and products, checked on the falling edge whenever an output transfer occurs.
module tb_booth_pp_gen_12x24;
  import booth_pp_gen_12x24_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic        pp_ready = 1'b0;
  logic [11:0] in_a = '0;
  logic [11:0] in_b = '0;
  logic        in_ready, pp_valid;
  logic [23:0] pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, pp9, pp10, pp11;

  typedef struct packed {
    pp_bus_t     rows;
    logic [23:0] prod;
  } exp_t;

  exp_t    q[$];
  int      tests = 0;
  int      fails = 0;
  int      cyc = 0;
  int      out_cnt = 0;
  int      out_cyc[64];
  pp_bus_t obs;

  assign obs = {pp11, pp10, pp9, pp8, pp7, pp6, pp5, pp4, pp3, pp2, pp1, pp0};

  booth_pp_gen_12x24 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .pp_valid(pp_valid), .pp_ready(pp_ready),
    .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3), .pp4(pp4), .pp5(pp5),
    .pp6(pp6), .pp7(pp7), .pp8(pp8), .pp9(pp9), .pp10(pp10), .pp11(pp11)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Rows as defined for the tree: b[i] selects a_ext<<i, top row negated when signed.
  function automatic pp_bus_t model_rows(input logic [11:0] a, input logic [11:0] b,
                                         input logic s);
    pp_bus_t     r;
    logic [23:0] ae, base;
    ae = s ? {{12{a[11]}}, a} : {12'h000, a};
    for (int i = 0; i < 12; i++) begin
      base = (i == 11 && s) ? (24'd0 - ae) : ae;
      r[i] = b[i] ? (base << i) : 24'd0;
    end
    return r;
  endfunction

  function automatic logic [23:0] ref_prod(input logic [11:0] a, input logic [11:0] b,
                                           input logic s);
    longint x, y, p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[23:0];
  endfunction

  function automatic logic [23:0] row_sum(input pp_bus_t r);
    logic [23:0] s;
    s = '0;
    for (int i = 0; i < 12; i++) s = s + r[i];
    return s;
  endfunction

  // Scoreboard check on every output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && pp_valid && pp_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 288'd1, 288'd0);
      end else begin
        e = q.pop_front();
        chk("rows", obs, e.rows);
        chk("row_sum", 288'(row_sum(obs)), 288'(e.prod));
        if (out_cnt < 64) out_cyc[out_cnt] = cyc;
        out_cnt++;
      end
    end
  end

  // Present an op and hold it until accepted; expectation is queued at acceptance.
  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic s,
                      input logic [23:0] prod);
    bit done;
    done = 1'b0;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{rows: model_rows(a, b, s), prod: prod});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 288'd0, 288'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && q.size() != 0; t++) @(negedge clk);
    chk("drain_empty", 288'(q.size()), 288'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          base;
    pp_bus_t     snap;
    logic [11:0] ra, rb;
    logic        rs;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pp_valid", 288'(pp_valid), 288'd0);
    chk("reset_rows", obs, 288'd0);
    chk("reset_in_ready", 288'(in_ready), 288'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pp_ready = 1'b1;

    // Unsigned 3*5 with latency check
    send(12'd3, 12'd5, 1'b0, 24'd15);
    @(negedge clk);
    chk("latency_1cyc_not_valid", 288'(pp_valid), 288'd0);
    @(negedge clk);
    chk("latency_2cyc_valid", 288'(pp_valid), 288'd1);
    chk("pp0_3x5", 288'(pp0), 288'h000003);
    chk("pp2_3x5", 288'(pp2), 288'h00000C);
    @(posedge clk); #1;
    drain();

    // Signed and unsigned boundaries
    send(12'hFFF, 12'h001, 1'b1, 24'hFFFFFF);
    send(12'h800, 12'h800, 1'b1, 24'h400000);
    send(12'hFFF, 12'hFFF, 1'b0, 24'hFFE001);
    send(12'hFFF, 12'hFFF, 1'b1, 24'h000001);
    send(12'h5A5, 12'h000, 1'b1, 24'h000000);
    drain();

    // Back-to-back stream of random ops
    base = out_cnt;
    for (int i = 0; i < 8; i++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, ref_prod(ra, rb, rs));
    end
    drain();
    chk("stream_count", 288'(out_cnt - base), 288'd8);
    chk("stream_no_bubble", 288'(out_cyc[base+7] - out_cyc[base]), 288'd7);

    // Backpressure: two accepts fill the pipe, then the outputs must hold
    pp_ready = 1'b0;
    send(12'h123, 12'h456, 1'b0, ref_prod(12'h123, 12'h456, 1'b0));
    send(12'hABC, 12'h0F7, 1'b1, ref_prod(12'hABC, 12'h0F7, 1'b1));
    chk("stall_in_ready_low", 288'(in_ready), 288'd0);
    chk("stall_pp_valid", 288'(pp_valid), 288'd1);
    snap = obs;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_rows_hold", obs, snap);
      chk("stall_valid_hold", 288'(pp_valid), 288'd1);
      chk("stall_in_ready_hold", 288'(in_ready), 288'd0);
    end
    @(posedge clk); #1;
    pp_ready = 1'b1;
    send(12'h7FF, 12'h801, 1'b1, ref_prod(12'h7FF, 12'h801, 1'b1));
    drain();

    // Reset with two ops in flight
    pp_ready = 1'b0;
    send(12'h0AA, 12'h055, 1'b0, ref_prod(12'h0AA, 12'h055, 1'b0));
    send(12'h321, 12'h00F, 1'b0, ref_prod(12'h321, 12'h00F, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("midreset_pp_valid", 288'(pp_valid), 288'd0);
    chk("midreset_rows", obs, 288'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_reset_no_output", 288'(pp_valid), 288'd0);
    end
    @(posedge clk); #1;
    send(12'd7, 12'd9, 1'b0, 24'd63);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
